// File: rtl/button_event_arbiter.sv
// Button event arbiter: turns debounced levels into press/release/repeat events
// and hands them one at a time, round-robin across buttons, to a valid/ready consumer.
module button_event_arbiter #(
  parameter int N_BUTTONS     = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BUTTONS-1:0]         clean_in,
  input  logic                         repeat_en,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [$clog2(N_BUTTONS)-1:0] evt_id,
  output logic [1:0]                   evt_kind,
  output logic [N_BUTTONS-1:0]         held,
  output logic                         overflow,
  input  logic                         overflow_clr
);
  localparam int IDW = $clog2(N_BUTTONS);
  localparam int CW  = $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] CNT_RLD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [N_BUTTONS-1:0] r_press, r_rel, r_rep;
  logic [IDW-1:0]       r_last;
  logic [N_BUTTONS-1:0] w_rise, w_fall, w_fire, w_pend;
  logic [N_BUTTONS-1:0] w_clr_press, w_clr_rel, w_clr_rep;
  logic [N_BUTTONS-1:0] w_ovf_vec;
  logic                 w_take, w_found;
  logic [IDW-1:0]       w_win;
  logic [1:0]           w_kind;

  assign w_rise = clean_in & ~held;
  assign w_fall = ~clean_in & held;
  assign w_pend = r_press | r_rel | r_rep;
  assign w_take = ~evt_valid | evt_ready;

  // Round-robin search starting just after the last granted button.
  always_comb begin : rr_pick
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 1; k <= N_BUTTONS; k++) begin
      idx = int'(r_last) + k;
      if (idx >= N_BUTTONS) idx = idx - N_BUTTONS;
      if (!w_found && w_pend[IDW'(idx)]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_clr_press = '0;
    w_clr_rel   = '0;
    w_clr_rep   = '0;
    w_kind      = 2'b00;
    if (w_take && w_found) begin
      if (r_press[w_win]) begin
        w_clr_press[w_win] = 1'b1;
        w_kind             = 2'b00;
      end else if (r_rel[w_win]) begin
        w_clr_rel[w_win] = 1'b1;
        w_kind           = 2'b01;
      end else begin
        w_clr_rep[w_win] = 1'b1;
        w_kind           = 2'b10;
      end
    end
  end

  // A flag that survives this edge's load and is hit again means a merged event.
  assign w_ovf_vec = (r_press & ~w_clr_press & w_rise) | (r_rel & ~w_clr_rel & w_fall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held      <= '0;
      r_press   <= '0;
      r_rel     <= '0;
      r_rep     <= '0;
      r_last    <= IDW'(N_BUTTONS - 1);
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_kind  <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      held    <= clean_in;
      r_press <= (r_press & ~w_clr_press) | w_rise;
      r_rel   <= (r_rel & ~w_clr_rel) | w_fall;
      r_rep   <= ((r_rep & ~w_clr_rep) | w_fire) & ~w_fall;
      if (w_ovf_vec != '0)   overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      if (w_take) begin
        evt_valid <= w_found;
        if (w_found) begin
          evt_id   <= w_win;
          evt_kind <= w_kind;
          r_last   <= w_win;
        end
      end
    end
  end

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_rep
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                        r_cnt <= '0;
      else if (held[g] && repeat_en)  r_cnt <= (r_cnt == CNT_TOP) ? CNT_RLD : r_cnt + 1'b1;
      else                            r_cnt <= '0;
    end
    assign w_fire[g] = held[g] & repeat_en & (r_cnt == CNT_TOP);
  end
endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench: a cycle-level event model feeds an expected-event queue,
// and a negedge monitor compares every handshake and status output against it.
module tb_button_event_arbiter;
  localparam int N = 4;
  localparam int D = 8;
  localparam int P = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] clean_in = '0;
  logic         repeat_en = 1'b0;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [1:0]   evt_id;
  logic [1:0]   evt_kind;
  logic [N-1:0] held;
  logic         overflow;
  logic         overflow_clr = 1'b0;

  always #5 clk = ~clk;

  button_event_arbiter #(.N_BUTTONS(N), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .clean_in(clean_in), .repeat_en(repeat_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_kind(evt_kind),
    .held(held), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  typedef struct packed { logic [1:0] id; logic [1:0] kind; } ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // reference state: pending events as bit sets, repeat timing as run lengths
  logic [N-1:0] m_held, m_pp, m_rp, m_rep;
  int           m_run [N];
  logic         m_valid, m_ovf;
  int           m_last;

  task automatic model_reset();
    m_held = '0; m_pp = '0; m_rp = '0; m_rep = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_valid = 1'b0; m_ovf = 1'b0; m_last = N - 1;
    exp_q.delete();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, predict the edge, commit the prediction after it.
  task automatic cyc(input logic [N-1:0] ci, input logic en, input logic rdy, input logic oclr);
    logic [N-1:0] pp, rp, rep, rise, fall, fire;
    logic take, found, ovf_ev;
    int win, kind;
    int nrun [N];
    ev_t ev;
    clean_in = ci; repeat_en = en; evt_ready = rdy; overflow_clr = oclr;
    pp = m_pp; rp = m_rp; rep = m_rep;
    take = !m_valid || rdy;
    found = 1'b0; win = 0; kind = 0;
    if (take)
      for (int j = 1; j <= N; j++) begin
        int b;
        b = (m_last + j) % N;
        if (!found && (pp[b] || rp[b] || rep[b])) begin found = 1'b1; win = b; end
      end
    if (found) begin
      if (pp[win])      begin kind = 0; pp[win] = 1'b0; end
      else if (rp[win]) begin kind = 1; rp[win] = 1'b0; end
      else              begin kind = 2; rep[win] = 1'b0; end
    end
    rise = ci & ~m_held;
    fall = ~ci & m_held;
    ovf_ev = |((pp & rise) | (rp & fall));
    for (int i = 0; i < N; i++) begin
      if (m_held[i] && en) begin
        fire[i] = (m_run[i] >= D - 1) && (((m_run[i] - (D - 1)) % P) == 0);
        nrun[i] = m_run[i] + 1;
      end else begin
        fire[i] = 1'b0;
        nrun[i] = 0;
      end
    end
    pp = pp | rise;
    rp = rp | fall;
    rep = (rep | fire) & ~fall;
    @(posedge clk);
    m_pp = pp; m_rp = rp; m_rep = rep; m_held = ci;
    m_ovf = ovf_ev || (m_ovf && !oclr);
    for (int i = 0; i < N; i++) m_run[i] = nrun[i];
    if (take) begin
      m_valid = found;
      if (found) begin
        m_last = win;
        ev.id = 2'(win); ev.kind = 2'(kind);
        exp_q.push_back(ev);
      end
    end
    #1;
  endtask

  int   ncyc = 0;
  int   press_cyc = 0;
  int   rep_log[$];
  ev_t  mon_ev;

  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      checks++;
      if (held !== m_held) begin errors++; $display("FAIL held act=%b exp=%b", held, m_held); end
      checks++;
      if (overflow !== m_ovf) begin errors++; $display("FAIL overflow act=%b exp=%b", overflow, m_ovf); end
      checks++;
      if (evt_valid !== m_valid) begin errors++; $display("FAIL evt_valid act=%b exp=%b", evt_valid, m_valid); end
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event act=id%0d/kind%0d exp=none", evt_id, evt_kind);
        end else begin
          mon_ev = exp_q.pop_front();
          if (evt_id !== mon_ev.id || evt_kind !== mon_ev.kind) begin
            errors++;
            $display("FAIL event act=id%0d/kind%0d exp=id%0d/kind%0d", evt_id, evt_kind, mon_ev.id, mon_ev.kind);
          end
        end
        if (evt_kind == 2'b10) rep_log.push_back(ncyc);
        else if (evt_kind == 2'b00) press_cyc = ncyc;
      end
    end
  end

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id",    32'(evt_id),    0);
    chk("rst_kind",  32'(evt_kind),  0);
    chk("rst_held",  32'(held),      0);
    chk("rst_ovf",   32'(overflow),  0);
    model_reset();
    clean_in = '0; evt_ready = 1'b0; repeat_en = 1'b0; overflow_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] ci;
    logic en, rdy, oclr;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("init_valid", 32'(evt_valid), 0);
    chk("init_held",  32'(held),      0);
    rst = 1'b0;

    // single press latency and one-cycle pulse
    cyc(4'b0000, 0, 1, 0); cyc(4'b0000, 0, 1, 0);
    cyc(4'b0100, 0, 1, 0); chk("lat_k", 32'(evt_valid), 0);
    cyc(4'b0100, 0, 1, 0); chk("lat_k1", 32'(evt_valid), 1);
    chk("lat_id", 32'(evt_id), 2); chk("lat_kind", 32'(evt_kind), 0);
    cyc(4'b0100, 0, 1, 0); chk("lat_pulse", 32'(evt_valid), 0);
    cyc(4'b0000, 0, 1, 0); cyc(4'b0000, 0, 1, 0); cyc(4'b0000, 0, 1, 0);

    // all four pressed at once: round-robin from reset grants 0,1,2,3
    pulse_reset();
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b1111, 0, 1, 0);
    for (int i = 0; i < N; i++) begin
      cyc(4'b1111, 0, 1, 0);
      chk("rr_valid", 32'(evt_valid), 1);
      chk("rr_id", 32'(evt_id), 32'(i));
    end
    cyc(4'b1111, 0, 1, 0); chk("rr_done", 32'(evt_valid), 0);
    for (int i = 0; i < 8; i++) cyc(4'b0000, 0, 1, 0);

    // merged events on a blocked slot set overflow; clear afterwards
    cyc(4'b1000, 0, 0, 0);
    cyc(4'b1010, 0, 0, 0);
    cyc(4'b1000, 0, 0, 0);
    cyc(4'b1010, 0, 0, 0); chk("ovf_set", 32'(overflow), 1);
    for (int i = 0; i < 6; i++) cyc(4'b1010, 0, 1, 0);
    chk("ovf_sticky", 32'(overflow), 1);
    cyc(4'b1010, 0, 1, 1); chk("ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 6; i++) cyc(4'b0000, 0, 1, 0);

    // auto-repeat timing relative to the press
    rep_log.delete();
    for (int i = 0; i < 20; i++) cyc(4'b0001, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 1, 1, 0);
    chk("rep_count", 32'(rep_log.size()), 4);
    for (int i = 0; i < rep_log.size() && i < 4; i++)
      chk("rep_delta", 32'(rep_log[i] - press_cyc), 32'(D + P * i));
    rep_log.delete();
    for (int i = 0; i < 20; i++) cyc(4'b0001, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 0, 1, 0);
    chk("rep_off", 32'(rep_log.size()), 0);

    // reset mid-handshake with three events still pending
    cyc(4'b1111, 0, 0, 0);
    cyc(4'b1111, 0, 1, 0);
    chk("pre_rst_valid", 32'(evt_valid), 1);
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0000, 0, 1, 0);
      chk("post_rst_quiet", 32'(evt_valid), 0);
    end

    // randomized traffic
    ci = '0;
    for (int t = 0; t < 1500; t++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 15) == 0) ci[b] = ~ci[b];
      en   = ($urandom_range(0, 9) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      oclr = ($urandom_range(0, 7) == 0);
      cyc(ci, en, rdy, oclr);
    end
    for (int i = 0; i < 12; i++) cyc(ci, 0, 1, 0);
    chk("drain_q", 32'(exp_q.size()), 0);
    chk("drain_valid", 32'(evt_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter N_BUTTONS, default 4, number of debounced inputs (2..16).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, cycles from press to first repeat event.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between subsequent repeat events (1 <= REPEAT_PERIOD <= REPEAT_DELAY).
REQ-004 SHALL have port clk  input  1  50MHz clock; the single clock of the block.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clean_in  input  N_BUTTONS  debounced button levels, synchronous to clk.
REQ-007 SHALL have port repeat_en  input  1  enables auto-repeat generation.
REQ-008 SHALL have port evt_valid  output  1  event slot holds an event.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts the event.
REQ-010 SHALL have port evt_id  output  clog2(N_BUTTONS)  button index of the event.
REQ-011 SHALL have port evt_kind  output  2  00 press, 01 release, 10 repeat; 11 never driven.
REQ-012 SHALL have port held  output  N_BUTTONS  registered copy of clean_in.
REQ-013 SHALL have port overflow  output  1  sticky lost-event flag.
REQ-014 SHALL have port overflow_clr  input  1  clears overflow.

Function
REQ-015 SHALL register clean_in into held every cycle; bit i rising (clean_in[i]=1, held[i]=0) SHALL set press_pend[i], falling SHALL set rel_pend[i], on that same edge.
REQ-016 SHALL keep per-button pending flags press_pend, rel_pend, rep_pend, cleared only when that event is loaded into the output slot.
REQ-017 SHALL hold a one-entry output slot (evt_valid/evt_id/evt_kind), stable while evt_valid=1 and evt_ready=0.
REQ-018 SHALL consume the slot on an edge with evt_valid=1 and evt_ready=1; the slot SHALL reload on that same edge if any flag is pending (throughput 1 event/cycle).
REQ-019 SHALL load the slot when it is empty or being consumed, choosing the button round-robin: search from last_grant+1 modulo N_BUTTONS, first button with any pending flag wins; last_grant updates to the winner.
REQ-020 Within one button, SHALL select press before release before repeat.
REQ-021 Latency: clean_in change sampled on edge k SHALL yield evt_valid=1 after edge k+1 when slot free and no other pending.
REQ-022 A new edge setting a flag already set and not loaded on that edge SHALL set overflow; the flag stays set (events merged).
REQ-023 A flag loaded and re-set on the same edge SHALL remain set with no overflow.
REQ-024 Repeat counter i SHALL run while held[i]=1 and repeat_en=1, starting at 0 on press; at count REPEAT_DELAY-1 SHALL set rep_pend[i] and reload to REPEAT_DELAY-REPEAT_PERIOD.
REQ-025 Counter i SHALL clear to 0 whenever held[i]=0 or repeat_en=0; a repeat colliding with set rep_pend[i] SHALL be dropped silently (no overflow).
REQ-026 release SHALL clear rep_pend[i] on the same edge rel_pend[i] is set.
REQ-027 overflow_clr=1 SHALL clear overflow unless an overflow condition occurs on the same edge (set wins).

Reset
REQ-028 rst=1 SHALL immediately, asynchronously, force evt_valid=0, evt_id=0, evt_kind=00, held=0, overflow=0, all pending flags and repeat counters 0, last_grant=N_BUTTONS-1.
REQ-029 Buttons high when rst deasserts SHALL produce press events on the following edges (held restarts at 0).
REQ-030 rst asserted mid-handshake SHALL discard the slot and all pending events; no event SHALL be emitted for pre-reset edges.

Verification (N_BUTTONS=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-031 clean_in 0000->0100, evt_ready=1 -> evt_valid=1 two edges later, evt_id=2, evt_kind=00, for exactly one cycle.
REQ-032 clean_in 0000->1111 in one cycle, evt_ready=1 -> presses for ids 0,1,2,3 on consecutive cycles.
REQ-033 evt_ready=0, button 1 press, release, press -> overflow=1; after evt_ready=1 exactly one press then one release for id 1; overflow_clr -> overflow=0.
REQ-034 repeat_en=1, button 0 held 20 cycles, evt_ready=1 -> press, repeats at cycles 8, 11, 14, 17 after press, release; repeat_en=0 -> no repeats.
REQ-035 rst pulsed while evt_valid=1 with 3 pending -> outputs 0 immediately; clean_in=0000 after reset -> no events.
